// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation arbiter: FSM state encoding,
// opcode / one-hot widths and the execution counter width.
package alu_pkg;

  // Opcode and decoded operation-enable widths
  localparam int OP_W  = 4;
  localparam int OH_W  = 16;

  // Execution down-counter width; EXEC_CYC is limited to 1..15
  localparam int CNT_W = 4;

  // FSM state encoding (plain constants for legacy tool compatibility)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef logic [OP_W-1:0] opcode_t;
  typedef logic [OH_W-1:0] onehot_t;

endpackage : alu_pkg

// File: rtl/op_onehot_dec.sv
// 4-to-16 one-hot decoder with enable; output is all zeros when disabled.
module op_onehot_dec
  import alu_pkg::*;
(
  input  logic [OP_W-1:0] sel_i,
  input  logic            en_i,
  output logic [OH_W-1:0] onehot_o
);

  // Decode the opcode into a single enabled operation bit
  always_comb begin
    onehot_o = {OH_W{1'b0}};
    if (en_i) begin
      onehot_o = OH_W'(1'b1) << sel_i;
    end else begin
      onehot_o = {OH_W{1'b0}};
    end
  end

endmodule : op_onehot_dec

// File: rtl/alu_op_arbiter.sv
// Round-robin arbiter that grants one requester at a time access to the ALU,
// holds the decoded operation enable for EXEC_CYC cycles, then acknowledges.
// All outputs come straight from flops.
module alu_op_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int EXEC_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*OP_W-1:0] op_sel,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      gnt,
  output logic [OH_W-1:0]      op_onehot,
  output logic                 op_en,
  output logic                 busy
);

  localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYC - 1);
  localparam logic [IW-1:0]    LAST_RST = IW'(NREQ - 1);

  // State and registered outputs
  logic [1:0]       state_q,    state_d;
  logic [IW-1:0]    win_q,      win_d;
  logic [IW-1:0]    last_win_q, last_win_d;
  logic [OP_W-1:0]  opcode_q,   opcode_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [NREQ-1:0]  gnt_q,      gnt_d;
  logic [NREQ-1:0]  ack_q,      ack_d;
  logic [OH_W-1:0]  onehot_q,   onehot_d;
  logic             op_en_q,    op_en_d;
  logic             busy_q,     busy_d;

  // Round-robin search results
  logic             found_s;
  logic [IW-1:0]    rr_idx_s;
  logic [IW-1:0]    cand_s;
  logic [OP_W-1:0]  sel_op_s;
  logic             dec_en_s;

  // Round-robin winner: first requester at or after last_winner+1 (mod NREQ)
  always_comb begin
    found_s  = 1'b0;
    rr_idx_s = {IW{1'b0}};
    cand_s   = {IW{1'b0}};
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IW'((int'(last_win_q) + k) % NREQ);
      if (!found_s && req[cand_s]) begin
        found_s  = 1'b1;
        rr_idx_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Opcode field of the round-robin candidate
  always_comb begin
    sel_op_s = {OP_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (rr_idx_s == IW'(i)) begin
        sel_op_s = op_sel[i*OP_W +: OP_W];
      end else begin
        sel_op_s = sel_op_s;
      end
    end
  end

  // FSM next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    last_win_d = last_win_q;
    opcode_d   = opcode_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    ack_d      = {NREQ{1'b0}};
    op_en_d    = op_en_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          // Winner and opcode are latched here so later input changes are ignored
          state_d  = ST_EXEC;
          win_d    = rr_idx_s;
          opcode_d = sel_op_s;
          cnt_d    = CNT_LOAD;
          gnt_d    = NREQ'(1'b1) << rr_idx_s;
          op_en_d  = 1'b1;
        end else begin
          gnt_d    = {NREQ{1'b0}};
          op_en_d  = 1'b0;
        end
      end
      ST_EXEC: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          // Last execute cycle: ack pulses even if the winner has dropped req
          state_d = ST_DONE;
          op_en_d = 1'b0;
          ack_d   = gnt_q;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1'b1);
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        gnt_d      = {NREQ{1'b0}};
        op_en_d    = 1'b0;
        last_win_d = win_q;
      end
      default: begin
        state_d  = ST_IDLE;
        gnt_d    = {NREQ{1'b0}};
        op_en_d  = 1'b0;
        cnt_d    = {CNT_W{1'b0}};
      end
    endcase
    busy_d   = (state_d != ST_IDLE);
    dec_en_s = (state_d == ST_EXEC);
  end

  // One-hot operation enable for the next cycle; zero outside EXEC
  op_onehot_dec u_dec (
    .sel_i    (opcode_d),
    .en_i     (dec_en_s),
    .onehot_o (onehot_d)
  );

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      win_q      <= {IW{1'b0}};
      last_win_q <= LAST_RST;
      opcode_q   <= {OP_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      gnt_q      <= {NREQ{1'b0}};
      ack_q      <= {NREQ{1'b0}};
      onehot_q   <= {OH_W{1'b0}};
      op_en_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_win_q <= last_win_d;
      opcode_q   <= opcode_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      onehot_q   <= onehot_d;
      op_en_q    <= op_en_d;
      busy_q     <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign gnt       = gnt_q;
  assign op_onehot = onehot_q;
  assign op_en     = op_en_q;
  assign busy      = busy_q;

endmodule : alu_op_arbiter

// File: tb/tb_alu_op_arbiter.sv
// Directed self-checking bench for alu_op_arbiter (NREQ=4, EXEC_CYC=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_op_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] op_sel;
  logic [3:0]  ack;
  logic [3:0]  gnt;
  logic [15:0] op_onehot;
  logic        op_en;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  alu_op_arbiter #(.NREQ(4), .EXEC_CYC(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_sel    (op_sel),
    .ack       (ack),
    .gnt       (gnt),
    .op_onehot (op_onehot),
    .op_en     (op_en),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic [3:0] e_ack,
                         input logic [15:0] e_oh, input logic e_en, input logic e_busy);
    chk({tag, ".gnt"},  {28'd0, gnt},       {28'd0, e_gnt});
    chk({tag, ".ack"},  {28'd0, ack},       {28'd0, e_ack});
    chk({tag, ".oh"},   {16'd0, op_onehot}, {16'd0, e_oh});
    chk({tag, ".en"},   {31'd0, op_en},     {31'd0, e_en});
    chk({tag, ".busy"}, {31'd0, busy},      {31'd0, e_busy});
  endtask

  initial begin
    logic [3:0] exp_g;
    rst_n  = 1'b0;
    req    = 4'b0000;
    op_sel = 16'h0000;

    // Reset state
    tick();
    chk_all("reset", 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0);

    // Single request: requester 2, opcode 5
    rst_n  = 1'b1;
    req    = 4'b0100;
    op_sel = 16'h0500;
    tick();
    chk_all("single.e1", 4'b0100, 4'b0000, 16'h0020, 1'b1, 1'b1);
    tick();
    chk_all("single.e2", 4'b0100, 4'b0000, 16'h0020, 1'b1, 1'b1);
    tick();
    chk_all("single.done", 4'b0100, 4'b0100, 16'h0000, 1'b0, 1'b1);
    req = 4'b0000;
    tick();
    chk_all("single.idle", 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0);

    // Full contention after reset: order 0,1,2,3,0 with one idle cycle between
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    req    = 4'b1111;
    op_sel = 16'h3210;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      tick();
      chk_all($sformatf("rr%0d.e1", k), exp_g, 4'b0000, 16'h0001 << (k % 4), 1'b1, 1'b1);
      tick();
      chk_all($sformatf("rr%0d.e2", k), exp_g, 4'b0000, 16'h0001 << (k % 4), 1'b1, 1'b1);
      tick();
      chk_all($sformatf("rr%0d.done", k), exp_g, exp_g, 16'h0000, 1'b0, 1'b1);
      tick();
      chk_all($sformatf("rr%0d.idle", k), 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0);
    end
    req = 4'b0000;

    // Opcode change mid-operation: requester 1, opcode F then 0
    tick();
    req    = 4'b0010;
    op_sel = 16'h00F0;
    tick();
    chk_all("opchg.e1", 4'b0010, 4'b0000, 16'h8000, 1'b1, 1'b1);
    op_sel = 16'h0000;
    tick();
    chk_all("opchg.e2", 4'b0010, 4'b0000, 16'h8000, 1'b1, 1'b1);
    tick();
    chk_all("opchg.done", 4'b0010, 4'b0010, 16'h0000, 1'b0, 1'b1);
    req = 4'b0000;
    tick();
    chk_all("opchg.idle", 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0);

    // Withdrawal: requester 3 drops req in its first EXEC cycle
    req    = 4'b1000;
    op_sel = 16'h7000;
    tick();
    chk_all("wd.e1", 4'b1000, 4'b0000, 16'h0080, 1'b1, 1'b1);
    req = 4'b0000;
    tick();
    chk_all("wd.e2", 4'b1000, 4'b0000, 16'h0080, 1'b1, 1'b1);
    tick();
    chk_all("wd.done", 4'b1000, 4'b1000, 16'h0000, 1'b0, 1'b1);
    tick();
    chk_all("wd.idle", 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0);

    // Asynchronous reset mid-EXEC, then requester 3 is granted after release
    req    = 4'b0001;
    op_sel = 16'h0009;
    tick();
    chk_all("ar.e1", 4'b0001, 4'b0000, 16'h0200, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_all("ar.async", 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0);
    req = 4'b0000;
    tick();
    chk_all("ar.held", 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0);
    rst_n  = 1'b1;
    req    = 4'b1000;
    op_sel = 16'h1000;
    tick();
    chk_all("ar.g3", 4'b1000, 4'b0000, 16'h0002, 1'b1, 1'b1);
    tick();
    tick();
    chk_all("ar.done", 4'b1000, 4'b1000, 16'h0000, 1'b0, 1'b1);
    req = 4'b0000;

    // Re-assert right after ack counts as a new request
    req = 4'b1000;
    tick();
    chk_all("rearm.idle", 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0);
    tick();
    chk_all("rearm.e1", 4'b1000, 4'b0000, 16'h0002, 1'b1, 1'b1);
    req = 4'b0000;
    tick();
    tick();
    chk_all("rearm.done", 4'b1000, 4'b1000, 16'h0000, 1'b0, 1'b1);
    tick();

    // Idle for 20 cycles: outputs stay zero, never Z
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("idle%0d.oh", c),   {16'd0, op_onehot}, 32'h0000_0000);
      chk($sformatf("idle%0d.en", c),   {31'd0, op_en},     32'h0000_0000);
      chk($sformatf("idle%0d.busy", c), {31'd0, busy},      32'h0000_0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_alu_op_arbiter

// File: doc/alu_op_arbiter.md
ALU_OP_ARBITER -- requirements
Module: alu_op_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters.
REQ-002 SHALL have parameter EXEC_CYC, default 2, meaning the cycles op_onehot is held per operation (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req, input, NREQ bits: per-requester operation request, level, held until ack.
REQ-006 SHALL have port op_sel, input, NREQ*4 bits: 4-bit opcode per requester; requester i uses bits [4i+3:4i].
REQ-007 SHALL have port ack, output, NREQ bits: one-cycle completion pulse to the granted requester.
REQ-008 SHALL have port gnt, output, NREQ bits: one-hot grant, held for the whole operation.
REQ-009 SHALL have port op_onehot, output, 16 bits: one-hot ALU operation enable, bit n for opcode n.
REQ-010 SHALL have port op_en, output, 1 bit: high while op_onehot is driven.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL implement the FSM states IDLE, EXEC and DONE.
REQ-013 IDLE: if any req bit is high, SHALL select a winner, latch its index and opcode, assert gnt, and enter EXEC on the next edge; otherwise it SHALL stay in IDLE.
REQ-014 SHALL select the winner round-robin: search starts at last_winner+1 modulo NREQ; after reset the search starts at index 0.
REQ-015 EXEC: SHALL drive op_en=1 and op_onehot=1<<latched_opcode for exactly EXEC_CYC cycles, counted by a down-counter loaded with EXEC_CYC-1.
REQ-016 When the counter reaches 0 in EXEC, SHALL enter DONE.
REQ-017 DONE: SHALL pulse ack[winner] for one cycle, drop op_en, set op_onehot=0, update last_winner, and return to IDLE.
REQ-018 gnt SHALL be high from the IDLE->EXEC transition through the DONE cycle inclusive, and zero otherwise.
REQ-019 Latency: with req[i] first sampled high at edge t in IDLE, op_en SHALL be high in cycles t+1..t+EXEC_CYC and ack[i] SHALL be high in cycle t+EXEC_CYC+1.
REQ-020 Outside EXEC, op_onehot SHALL be all zeros, never high-impedance.
REQ-021 Changes to op_sel or req during EXEC/DONE SHALL NOT alter the latched opcode or winner.
REQ-022 If the winner drops req mid-operation, the operation SHALL still complete and ack SHALL still pulse.
REQ-023 Requests arriving in EXEC/DONE SHALL wait; earliest possible next grant is the edge after DONE (one idle cycle between operations).
REQ-024 With all NREQ requesters continuously requesting, grants SHALL rotate 0,1,...,NREQ-1,0 with no starvation.
REQ-025 A requester that re-asserts req in the cycle after its ack SHALL be treated as a new request.

Reset
REQ-026 On rst_n low, SHALL immediately enter IDLE and clear gnt, ack, op_onehot, op_en and busy to 0, the counter to 0, and last_winner to NREQ-1.
REQ-027 Reset mid-EXEC SHALL abort the operation without an ack pulse; after rst_n is released, the first grant SHALL follow REQ-014.

Structure
REQ-028 The FSM state encoding, the opcode width (4) and the one-hot width (16) SHALL live in a shared package, alu_pkg.
REQ-029 The 4-to-16 one-hot generation SHALL be a sub-module, op_onehot_dec (select, enable -> 16-bit one-hot, zeros when disabled).
REQ-030 The round-robin winner logic SHALL be combinational from req and last_winner; all outputs SHALL be registered or decoded from registered state.

Verification
REQ-031 Single request: EXEC_CYC=2, req[2]=1, op_sel[11:8]=4'h5 at edge t -> op_onehot=16'h0020 and op_en=1 in cycles t+1..t+2, ack=4'b0100 in cycle t+3, then busy=0.
REQ-032 Full contention: req=4'b1111 held, after reset -> gnt order 0,1,2,3,0, each ack one cycle, one idle cycle between operations.
REQ-033 Opcode change mid-op: winner op_sel 4'hF->4'h0 during EXEC -> op_onehot stays 16'h8000 until DONE.
REQ-034 Withdrawal: winner drops req in its first EXEC cycle -> op_en still lasts EXEC_CYC cycles and ack still pulses.
REQ-035 Async reset: rst_n low mid-EXEC between clock edges -> all outputs 0 immediately, no ack; with req=4'b1000 after release -> grant goes to 3.
REQ-036 Idle: req=0 for 20 cycles -> op_onehot=0, op_en=0, busy=0 throughout, never Z.
